// File: rtl/uart_regbank_if.sv
// Register-access bus between the UART command decoder and the register bank.
// The master drives address, write data and strobes; the slave returns registered read data.
interface uart_regbank_if;
    logic [7:0] address;
    logic [7:0] data_write_to_reg;
    logic       reg_en;
    logic       write_en;
    logic [7:0] data_read_from_reg;

    modport master (
        output address, data_write_to_reg, reg_en, write_en,
        input  data_read_from_reg
    );

    modport slave (
        input  address, data_write_to_reg, reg_en, write_en,
        output data_read_from_reg
    );
endinterface

// File: rtl/uart_regbank.sv
// UART-accessible register bank: ID/VER, scratch, IRQ mask/status, command strobes, GP0..GP7.
// Define UART_REGBANK_EVT_CNT_EN to include the saturating clear-on-read event counter at 0x06.
module uart_regbank (
    input  logic                 clk,
    input  logic                 reset,
    uart_regbank_if.slave        bus,
    input  logic [7:0]           evt_in,
    input  logic                 cnt_evt,
    output logic [63:0]          gp_out,
    output logic [7:0]           cmd_pulse,
    output logic                 irq
);
    localparam logic [7:0] ADDR_ID       = 8'h00;
    localparam logic [7:0] ADDR_VER      = 8'h01;
    localparam logic [7:0] ADDR_SCRATCH  = 8'h02;
    localparam logic [7:0] ADDR_IRQ_MASK = 8'h03;
    localparam logic [7:0] ADDR_IRQ_STAT = 8'h04;
    localparam logic [7:0] ADDR_CMD      = 8'h05;
    localparam logic [7:0] ADDR_EVT_CNT  = 8'h06;
    localparam logic [7:0] ID_VALUE      = 8'hA5;
    localparam logic [7:0] VER_VALUE     = 8'h01;

    logic       wr_strobe;
    logic       rd_strobe;
    logic       gp_hit;
    logic [7:0] scratch_reg;
    logic [7:0] irq_mask_reg;
    logic [7:0] irq_stat_reg;
    logic [7:0] irq_stat_next;
    logic [7:0] irq_clear;
    logic [7:0] cmd_pulse_reg;
    logic       irq_reg;
    logic [7:0] rdata_reg;
    logic [7:0] read_value;
    logic [7:0] gp_reg [8];

    assign wr_strobe = bus.reg_en & bus.write_en;
    assign rd_strobe = bus.reg_en & ~bus.write_en;
    assign gp_hit    = (bus.address[7:3] == 5'b00010);

    // W1C clear applies first so a simultaneous event re-sets the bit.
    assign irq_clear     = (wr_strobe && bus.address == ADDR_IRQ_STAT) ? bus.data_write_to_reg : 8'h00;
    assign irq_stat_next = (irq_stat_reg & ~irq_clear) | evt_in;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scratch_reg   <= 8'h00;
            irq_mask_reg  <= 8'h00;
            irq_stat_reg  <= 8'h00;
            cmd_pulse_reg <= 8'h00;
            irq_reg       <= 1'b0;
        end else begin
            irq_stat_reg  <= irq_stat_next;
            irq_reg       <= |(irq_stat_reg & irq_mask_reg);
            cmd_pulse_reg <= (wr_strobe && bus.address == ADDR_CMD) ? bus.data_write_to_reg : 8'h00;
            if (wr_strobe && bus.address == ADDR_SCRATCH)
                scratch_reg <= bus.data_write_to_reg;
            if (wr_strobe && bus.address == ADDR_IRQ_MASK)
                irq_mask_reg <= bus.data_write_to_reg;
        end
    end

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_gp
            always_ff @(posedge clk or posedge reset) begin
                if (reset)
                    gp_reg[gi] <= 8'h00;
                else if (wr_strobe && gp_hit && bus.address[2:0] == 3'(gi))
                    gp_reg[gi] <= bus.data_write_to_reg;
            end
            assign gp_out[8*gi +: 8] = gp_reg[gi];
        end
    endgenerate

`ifdef UART_REGBANK_EVT_CNT_EN
    logic [7:0] evt_cnt_reg;
    logic       cnt_read;

    assign cnt_read = rd_strobe && bus.address == ADDR_EVT_CNT;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            evt_cnt_reg <= 8'h00;
        else if (cnt_read)
            evt_cnt_reg <= {7'd0, cnt_evt};
        else if (cnt_evt && evt_cnt_reg != 8'hFF)
            evt_cnt_reg <= evt_cnt_reg + 8'd1;
    end
`else
    wire unused_cnt_evt = cnt_evt;
`endif

    always_comb begin
        read_value = 8'h00;
        if (gp_hit) begin
            read_value = gp_reg[bus.address[2:0]];
        end else begin
            case (bus.address)
                ADDR_ID:       read_value = ID_VALUE;
                ADDR_VER:      read_value = VER_VALUE;
                ADDR_SCRATCH:  read_value = scratch_reg;
                ADDR_IRQ_MASK: read_value = irq_mask_reg;
                ADDR_IRQ_STAT: read_value = irq_stat_reg;
`ifdef UART_REGBANK_EVT_CNT_EN
                ADDR_EVT_CNT:  read_value = evt_cnt_reg;
`endif
                default:       read_value = 8'h00;
            endcase
        end
    end

    // Read data holds between reads so the UART side can serialise it at leisure.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            rdata_reg <= 8'h00;
        else if (rd_strobe)
            rdata_reg <= read_value;
    end

    assign bus.data_read_from_reg = rdata_reg;
    assign cmd_pulse              = cmd_pulse_reg;
    assign irq                    = irq_reg;
endmodule

// File: tb/tb_uart_regbank.sv
// Directed self-checking bench for uart_regbank; expectations follow the build selected
// by UART_REGBANK_EVT_CNT_EN.
module tb_uart_regbank;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  evt_in = 8'h00;
    logic        cnt_evt = 1'b0;
    logic [63:0] gp_out;
    logic [7:0]  cmd_pulse;
    logic        irq;
    int          total = 0;
    int          bad = 0;

    uart_regbank_if bus ();

    uart_regbank dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus.slave),
        .evt_in    (evt_in),
        .cnt_evt   (cnt_evt),
        .gp_out    (gp_out),
        .cmd_pulse (cmd_pulse),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) begin
            $display("check %-14s obs=%0h exp=%0h ok", tag, obs, exp);
        end else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One bus access; returns 1 time unit after the capturing edge.
    task automatic access(input logic we, input logic [7:0] a, input logic [7:0] d);
        bus.address           = a;
        bus.data_write_to_reg = d;
        bus.reg_en            = 1'b1;
        bus.write_en          = we;
        @(posedge clk); #1;
        bus.reg_en            = 1'b0;
        bus.write_en          = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        logic [7:0] cnt_small_exp;
        logic [7:0] cnt_sat_exp;
        logic [7:0] cnt_after_exp;
`ifdef UART_REGBANK_EVT_CNT_EN
        cnt_small_exp = 8'h05;
        cnt_sat_exp   = 8'hFF;
        cnt_after_exp = 8'h01;
`else
        cnt_small_exp = 8'h00;
        cnt_sat_exp   = 8'h00;
        cnt_after_exp = 8'h00;
`endif
        bus.address = 8'h00;
        bus.data_write_to_reg = 8'h00;
        bus.reg_en = 1'b0;
        bus.write_en = 1'b0;

        // Reset state and read-only identity registers
        @(posedge clk); #1;
        access(1'b1, 8'h02, 8'hEE);
        chk("rst_rdata", bus.data_read_from_reg, 8'h00);
        chk("rst_gp", gp_out, 64'h0);
        chk("rst_cmd", cmd_pulse, 8'h00);
        chk("rst_irq", irq, 1'b0);
        #2 reset = 1'b0;
        @(posedge clk); #1;
        access(1'b0, 8'h00, 8'h00);
        chk("rd_id", bus.data_read_from_reg, 8'hA5);
        access(1'b0, 8'h01, 8'h00);
        chk("rd_ver", bus.data_read_from_reg, 8'h01);
        access(1'b0, 8'h02, 8'h00);
        chk("rd_scratch0", bus.data_read_from_reg, 8'h00);
        access(1'b0, 8'h06, 8'h00);
        chk("rd_cnt0", bus.data_read_from_reg, 8'h00);

        // RW, RO-ignore, unmapped, GP
        access(1'b1, 8'h13, 8'h3C);
        chk("gp3", gp_out[31:24], 8'h3C);
        chk("rdata_hold", bus.data_read_from_reg, 8'h00);
        access(1'b1, 8'h02, 8'h5A);
        access(1'b0, 8'h02, 8'h00);
        chk("rd_scratch", bus.data_read_from_reg, 8'h5A);
        access(1'b1, 8'h00, 8'hFF);
        access(1'b0, 8'h00, 8'h00);
        chk("ro_ignored", bus.data_read_from_reg, 8'hA5);
        access(1'b1, 8'h20, 8'h11);
        access(1'b0, 8'h20, 8'h00);
        chk("unmapped", bus.data_read_from_reg, 8'h00);
        access(1'b1, 8'h17, 8'hC3);
        access(1'b0, 8'h17, 8'h00);
        chk("rd_gp7", bus.data_read_from_reg, 8'hC3);
        chk("gp_all", gp_out, 64'hC300_0000_3C00_0000);

        // Interrupt status / mask
        evt_in = 8'h81;
        @(posedge clk); #1;
        evt_in = 8'h00;
        access(1'b1, 8'h03, 8'h01);
        chk("irq_lag", irq, 1'b0);
        idle(1);
        chk("irq_set", irq, 1'b1);
        evt_in = 8'h01;
        access(1'b1, 8'h04, 8'h01);
        evt_in = 8'h00;
        access(1'b0, 8'h04, 8'h00);
        chk("stat_setwins", bus.data_read_from_reg, 8'h81);
        chk("irq_held", irq, 1'b1);
        access(1'b1, 8'h04, 8'h81);
        chk("irq_clr_lag", irq, 1'b1);
        idle(1);
        chk("irq_clr", irq, 1'b0);
        access(1'b0, 8'h04, 8'h00);
        chk("stat_clr", bus.data_read_from_reg, 8'h00);

        // Command strobe
        access(1'b1, 8'h05, 8'h06);
        chk("cmd_on", cmd_pulse, 8'h06);
        idle(1);
        chk("cmd_off", cmd_pulse, 8'h00);
        access(1'b0, 8'h05, 8'h00);
        chk("rd_cmd", bus.data_read_from_reg, 8'h00);

        // Event counter
        cnt_evt = 1'b1;
        idle(5);
        cnt_evt = 1'b0;
        access(1'b0, 8'h06, 8'h00);
        chk("cnt5", bus.data_read_from_reg, cnt_small_exp);
        cnt_evt = 1'b1;
        idle(300);
        access(1'b0, 8'h06, 8'h00);
        cnt_evt = 1'b0;
        chk("cnt_sat", bus.data_read_from_reg, cnt_sat_exp);
        access(1'b0, 8'h06, 8'h00);
        chk("cnt_reread", bus.data_read_from_reg, cnt_after_exp);

        // Back-to-back write then read
        access(1'b1, 8'h14, 8'h12);
        access(1'b0, 8'h14, 8'h00);
        chk("b2b", bus.data_read_from_reg, 8'h12);

        // Asynchronous reset mid-cycle with a pending strobe and active irq
        access(1'b1, 8'h10, 8'h77);
        access(1'b1, 8'h03, 8'hFF);
        evt_in = 8'h02;
        @(posedge clk); #1;
        evt_in = 8'h00;
        idle(1);
        chk("irq_pre", irq, 1'b1);
        access(1'b1, 8'h05, 8'h33);
        chk("cmd_pre", cmd_pulse, 8'h33);
        #2 reset = 1'b1;
        #1;
        chk("arst_gp", gp_out, 64'h0);
        chk("arst_irq", irq, 1'b0);
        chk("arst_cmd", cmd_pulse, 8'h00);
        chk("arst_rdata", bus.data_read_from_reg, 8'h00);
        idle(1);
        access(1'b1, 8'h02, 8'hAA);
        evt_in = 8'hFF;
        idle(1);
        evt_in = 8'h00;
        #3 reset = 1'b0;
        #1;
        access(1'b1, 8'h11, 8'h44);
        chk("first_edge", gp_out[15:8], 8'h44);
        access(1'b0, 8'h02, 8'h00);
        chk("rst_ign_wr", bus.data_read_from_reg, 8'h00);
        access(1'b0, 8'h04, 8'h00);
        chk("rst_ign_evt", bus.data_read_from_reg, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/uart_regbank.md
UART_REGBANK -- requirements
Module: uart_regbank

Interface
REQ-001 clk  input  1  system clock; all state is updated on its rising edge.
REQ-002 reset  input  1  asynchronous, active-high reset.
REQ-003 address  input  8  register address from the UART interface.
REQ-004 data_write_to_reg  input  8  write data.
REQ-005 reg_en  input  1  access strobe, one cycle wide.
REQ-006 write_en  input  1  qualifies reg_en; 1 = write, 0 = read.
REQ-007 data_read_from_reg  output  8  registered read data.
REQ-008 evt_in  input  8  event lines; each is a one-cycle synchronous pulse.
REQ-009 cnt_evt  input  1  counter increment pulse.
REQ-010 gp_out  output  64  general registers GP0..GP7; GPn drives bits [8n+7:8n].
REQ-011 cmd_pulse  output  8  self-clearing command strobes.
REQ-012 irq  output  1  interrupt request, registered.

Function
REQ-013 A write occurs on a cycle with reg_en=1 and write_en=1; a read occurs on a cycle with reg_en=1 and write_en=0.
REQ-014 Read: data_read_from_reg SHALL update on the clock edge after the read cycle (1-cycle latency) and SHALL hold its value until the next read.
REQ-015 Register map:
- 0x00 ID: RO, 0xA5.
- 0x01 VER: RO, 0x01.
- 0x02 SCRATCH: RW.
- 0x03 IRQ_MASK: RW.
- 0x04 IRQ_STAT: W1C.
- 0x05 CMD: WO, reads 0x00.
- 0x06 EVT_CNT: RO, clear-on-read.
- 0x10..0x17 GP0..GP7: RW.
REQ-016 An unmapped address SHALL read 0x00; a write to it SHALL have no effect.
REQ-017 A write to a RO address SHALL be ignored.
REQ-018 A write to CMD SHALL drive cmd_pulse = written data for exactly the next cycle; cmd_pulse SHALL be 0x00 otherwise.
REQ-019 IRQ_STAT[i] SHALL set on evt_in[i]=1.
REQ-020 Writing 1 to IRQ_STAT[i] SHALL clear that bit; writing 0 leaves it unchanged.
REQ-021 If a set and a clear of the same IRQ_STAT bit fall in one cycle, the set SHALL win.
REQ-022 irq SHALL equal the OR of (IRQ_STAT & IRQ_MASK), registered, so it lags the state change by one cycle.
REQ-023 EVT_CNT is 8-bit, increments on cnt_evt, and saturates at 0xFF.
REQ-024 Reading EVT_CNT SHALL return the pre-read value and clear the counter.
- If cnt_evt=1 in the read cycle, the counter SHALL become 0x01.
REQ-025 A read and a write never coincide (write_en qualifies reg_en).
- Back-to-back accesses on consecutive cycles SHALL all be honoured.
REQ-026 gp_out SHALL reflect a GP write on the cycle after the write.

Reset
REQ-027 When reset=1, all of the following SHALL be 0 immediately, independent of clk: data_read_from_reg, gp_out, cmd_pulse, irq, SCRATCH, IRQ_MASK, IRQ_STAT, EVT_CNT.
REQ-028 While reset=1, accesses and events SHALL be ignored.
REQ-029 After reset deasserts, the first clk edge SHALL be functional.
REQ-030 A reset during a pending cmd_pulse SHALL abort the pulse.

Configuration
REQ-031 Macro UART_REGBANK_EVT_CNT_EN controls the event counter.
REQ-032 With UART_REGBANK_EVT_CNT_EN defined:
- EVT_CNT is implemented per REQ-023 and REQ-024.
REQ-033 With UART_REGBANK_EVT_CNT_EN undefined:
- no counter logic exists;
- cnt_evt is ignored;
- address 0x06 reads 0x00.
REQ-034 All other behaviour SHALL be identical in both builds.

Verification
REQ-035 Reset, then read 0x00, 0x01, 0x02 -> data_read_from_reg = 0xA5, 0x01, 0x00, each 1 cycle after its reg_en.
REQ-036 Write 0x13=0x3C, then write 0x02=0x5A, read 0x02, write 0x00=0xFF, read 0x00 -> gp_out[31:24]=0x3C; 0x02 reads 0x5A; 0x00 still reads 0xA5.
REQ-037 Pulse evt_in=0x81, write 0x03=0x01 -> irq=1. Then write 0x04=0x01 in the same cycle as evt_in=0x01 -> IRQ_STAT stays 0x81 and irq stays 1. Then write 0x04=0x81 -> IRQ_STAT=0x00 and irq=0 one cycle later.
REQ-038 Write 0x05=0x06 -> cmd_pulse=0x06 for exactly 1 cycle, then 0x00; 0x05 reads 0x00.
REQ-039 Apply 300 cnt_evt pulses, then read 0x06 with cnt_evt=1 in the read cycle, then read 0x06 again -> 0xFF, then 0x01. In the build without the macro, both reads return 0x00.
REQ-040 Write 0x10=0x77 and 0x03=0xFF, then assert reset asynchronously between clk edges -> gp_out=0, irq=0, and cmd_pulse=0 immediately.
